// File: rtl/mux4to1_pkg.sv
// Shared constants, select type and lane-extraction helper for the registered 4-to-1 selector.
// The optional per-lane selection counters are enabled with MUX4TO1_SEL_CNT_EN.
package mux4to1_pkg;

    localparam int NUM_LANES  = 4;
    localparam int SEL_W      = 2;
    // Widest lane the helper can extract; lanes are zero-padded up to this width.
    localparam int LANE_MAX_W = 64;

    typedef logic [SEL_W-1:0] sel_t;

    // Returns lane s of a vector packed as NUM_LANES lanes of LANE_MAX_W bits, lane 0 in the LSBs.
    function automatic logic [LANE_MAX_W-1:0] lane_of(
        input logic [NUM_LANES*LANE_MAX_W-1:0] d,
        input sel_t                            s
    );
        lane_of = d[int'(s)*LANE_MAX_W +: LANE_MAX_W];
    endfunction

endpackage

// File: rtl/mux4to1_lane_sel.sv
// Combinational lane picker: returns lane s_i of the packed input d_i, bits taken verbatim.
// Used by mux4to1_reg (optional counters there are enabled with MUX4TO1_SEL_CNT_EN).
module mux4to1_lane_sel
    import mux4to1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [NUM_LANES*WIDTH-1:0] d_i,
    input  sel_t                       s_i,
    output logic [WIDTH-1:0]           lane_o
);

    logic [NUM_LANES*LANE_MAX_W-1:0] d_pad_s;

    // Re-pack the lanes onto the fixed LANE_MAX_W pitch the helper expects.
    always_comb begin
        d_pad_s = {(NUM_LANES*LANE_MAX_W){1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            d_pad_s[i*LANE_MAX_W +: LANE_MAX_W] = LANE_MAX_W'(d_i[i*WIDTH +: WIDTH]);
        end
    end

    assign lane_o = WIDTH'(lane_of(d_pad_s, s_i));

endmodule

// File: rtl/mux4to1_reg.sv
// Registered 4-to-1 lane selector with one-cycle latency, capture enable and valid flag.
// Define MUX4TO1_SEL_CNT_EN to add saturating per-lane selection counters cnt0..cnt3.
module mux4to1_reg
    import mux4to1_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LANES*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]           s,
    input  logic                       en,
    output logic [WIDTH-1:0]           y,
    output logic                       y_valid,
    output logic [SEL_W-1:0]           sel_q
`ifdef MUX4TO1_SEL_CNT_EN
    ,
    output logic [CNT_W-1:0]           cnt0,
    output logic [CNT_W-1:0]           cnt1,
    output logic [CNT_W-1:0]           cnt2,
    output logic [CNT_W-1:0]           cnt3
`endif
);

    if (WIDTH < 1 || WIDTH > LANE_MAX_W || CNT_W < 1) begin : g_param_err
        $error("mux4to1_reg: WIDTH must be 1..LANE_MAX_W and CNT_W at least 1");
    end

    logic [WIDTH-1:0] lane_s;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;
    logic             valid_q;
    logic             valid_d;
    logic [SEL_W-1:0] sel_d;

    mux4to1_lane_sel #(
        .WIDTH (WIDTH)
    ) u_lane_sel (
        .d_i    (d),
        .s_i    (s),
        .lane_o (lane_s)
    );

    // Capture on en; otherwise hold data and select but drop valid.
    always_comb begin
        y_d     = y_q;
        sel_d   = sel_q;
        valid_d = 1'b0;
        if (en) begin
            y_d     = lane_s;
            sel_d   = s;
            valid_d = 1'b1;
        end else begin
            y_d     = y_q;
            sel_d   = sel_q;
            valid_d = 1'b0;
        end
    end

    // Output register; reset wins over capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= {WIDTH{1'b0}};
            sel_q   <= {SEL_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign y       = y_q;
    assign y_valid = valid_q;

`ifdef MUX4TO1_SEL_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_LANES];
    logic [CNT_W-1:0] cnt_d [NUM_LANES];

    // The counter for the captured lane advances and sticks at all-ones.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (en && (s == SEL_W'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Counter registers, cleared together with the output register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (rst) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_mux4to1_reg.sv
// Directed scoreboard bench for mux4to1_reg: a WIDTH=1 (CNT_W=2) and a WIDTH=8 instance share one stimulus stream.
// Counter checks are compiled only with MUX4TO1_SEL_CNT_EN.
module tb_mux4to1_reg;

    typedef struct {
        logic       y1;
        logic [7:0] y8;
        logic       v;
        logic [1:0] sel;
        logic [1:0] cnt [4];
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  s;
    logic [3:0]  d1;
    logic [31:0] d8;
    logic        y1;
    logic [7:0]  y8;
    logic        yv1;
    logic        yv8;
    logic [1:0]  sq1;
    logic [1:0]  sq8;

    exp_t exp_q [$];
    exp_t m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef MUX4TO1_SEL_CNT_EN
    logic [1:0]  c1_0, c1_1, c1_2, c1_3;
    logic [15:0] c8_0, c8_1, c8_2, c8_3;
`endif

    mux4to1_reg #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .d       (d1),
        .s       (s),
        .en      (en),
        .y       (y1),
        .y_valid (yv1),
        .sel_q   (sq1)
`ifdef MUX4TO1_SEL_CNT_EN
        ,
        .cnt0    (c1_0),
        .cnt1    (c1_1),
        .cnt2    (c1_2),
        .cnt3    (c1_3)
`endif
    );

    mux4to1_reg #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .d       (d8),
        .s       (s),
        .en      (en),
        .y       (y8),
        .y_valid (yv8),
        .sel_q   (sq8)
`ifdef MUX4TO1_SEL_CNT_EN
        ,
        .cnt0    (c8_0),
        .cnt1    (c8_1),
        .cnt2    (c8_2),
        .cnt3    (c8_3)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare after the edge.
    task automatic step(input logic r, input logic e, input logic [1:0] sv,
                        input logic [3:0] dv1, input logic [31:0] dv8);
        exp_t ex;
        rst = r; en = e; s = sv; d1 = dv1; d8 = dv8;
        if (e && $isunknown(sv)) $display("protocol violation: s unknown while en=1");
        if (r) begin
            m.y1 = 1'b0; m.y8 = 8'h00; m.v = 1'b0; m.sel = 2'd0;
            for (int i = 0; i < 4; i++) m.cnt[i] = 2'd0;
        end else if (e) begin
            m.y1  = (dv1 >> sv) & 4'h1;
            m.y8  = 8'((dv8 >> (8 * sv)) & 32'hFF);
            m.v   = 1'b1;
            m.sel = sv;
            if (m.cnt[sv] != 2'd3) m.cnt[sv] = m.cnt[sv] + 2'd1;
        end else begin
            m.v = 1'b0;
        end
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed 0 expected 1");
        end
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            check("y1", {7'd0, y1}, {7'd0, ex.y1});
            check("y8", y8, ex.y8);
            check("valid1", {7'd0, yv1}, {7'd0, ex.v});
            check("valid8", {7'd0, yv8}, {7'd0, ex.v});
            check("sel1", {6'd0, sq1}, {6'd0, ex.sel});
            check("sel8", {6'd0, sq8}, {6'd0, ex.sel});
`ifdef MUX4TO1_SEL_CNT_EN
            check("cnt0", {6'd0, c1_0}, {6'd0, ex.cnt[0]});
            check("cnt1", {6'd0, c1_1}, {6'd0, ex.cnt[1]});
            check("cnt2", {6'd0, c1_2}, {6'd0, ex.cnt[2]});
            check("cnt3", {6'd0, c1_3}, {6'd0, ex.cnt[3]});
`endif
        end
    endtask

    localparam logic [31:0] WIDE = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

    initial begin
        m.y1 = 1'b0; m.y8 = 8'h00; m.v = 1'b0; m.sel = 2'd0;
        for (int i = 0; i < 4; i++) m.cnt[i] = 2'd0;
        rst = 1'b1; en = 1'b0; s = 2'd0; d1 = 4'h0; d8 = 32'h0;
        #2;
        // Reset held two cycles while en/s/d are active.
        step(1'b1, 1'b1, 2'd1, 4'b1010, WIDE);
        step(1'b1, 1'b1, 2'd1, 4'b1010, WIDE);
        // Exhaustive select, back to back.
        step(1'b0, 1'b1, 2'd0, 4'b1010, WIDE);
        step(1'b0, 1'b1, 2'd1, 4'b1010, WIDE);
        step(1'b0, 1'b1, 2'd2, 4'b1010, WIDE);
        step(1'b0, 1'b1, 2'd3, 4'b1010, WIDE);
        // Capture then hold with inputs changed.
        step(1'b0, 1'b1, 2'd2, 4'b0100, WIDE);
        step(1'b0, 1'b0, 2'd0, 4'b0000, 32'h0);
        step(1'b0, 1'b0, 2'd0, 4'b0000, 32'h0);
        // Wide lanes.
        step(1'b0, 1'b1, 2'd3, 4'b0001, WIDE);
        step(1'b0, 1'b1, 2'd0, 4'b0001, WIDE);
        // Reset priority over capture, then capture again.
        step(1'b1, 1'b1, 2'd3, 4'hF, WIDE);
        step(1'b0, 1'b1, 2'd3, 4'hF, WIDE);
        // A few random captures and holds.
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom), $urandom);
        end
        // Counter saturation: reset, five captures of lane 1, reset again.
        step(1'b1, 1'b0, 2'd0, 4'h0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 2'd1, 4'b0010, WIDE);
        end
        step(1'b1, 1'b1, 2'd1, 4'b0010, WIDE);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
